uart_tx_arbiter: RTL and testbench

//  Shares the single UART byte transmitter between NUM_REQ frame sources (capture reporter, status, debug).

---
 rtl/uart_tx_arbiter_if.sv | 34 +++
 rtl/uart_tx_arbiter.sv | 152 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// ============================================================================
// Module   : uart_tx_arbiter_if
// Purpose  : Requester/UART-side signal bundle of the UART TX frame arbiter.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ-1:0]   grant;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 tx_done;
  logic                 busy;
  logic                 timeout_err;

  modport slave (
    input  req_valid, req_data, req_last, tx_done,
    output req_ready, grant, tx_start, tx_data, busy, timeout_err
  );

  modport master (
    output req_valid, req_data, req_last, tx_done,
    input  req_ready, grant, tx_start, tx_data, busy, timeout_err
  );
endinterface

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Round-robin whole-frame arbiter feeding one UART transmitter.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int GAP_CYCLES     = 600,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  uart_tx_arbiter_if.slave  bus
);

  localparam int c_PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int c_GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int c_TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_LOAD = 2'd1;
  localparam logic [1:0] c_WAIT = 2'd2;
  localparam logic [1:0] c_GAP  = 2'd3;

  // With no gap configured a finished frame goes straight back to IDLE.
  localparam logic [1:0]      c_AFTER_FRAME = (GAP_CYCLES == 0) ? c_IDLE : c_GAP;
  localparam logic            c_AFTER_BUSY  = (GAP_CYCLES != 0);
  localparam logic [c_GW-1:0] c_GAP_LAST    = c_GW'(GAP_CYCLES - 1);
  localparam logic [c_TW-1:0] c_TO_LIMIT    = c_TW'(TIMEOUT_CYCLES);
  localparam logic [c_PW-1:0] c_PTR_LAST    = c_PW'(NUM_REQ - 1);

  logic [1:0]         r_state;
  logic [c_PW-1:0]    r_rr;
  logic [c_PW-1:0]    r_owner;
  logic               r_last;
  logic [c_GW-1:0]    r_gap_cnt;
  logic [c_TW-1:0]    r_to_cnt;
  logic [NUM_REQ-1:0] r_grant;
  logic [NUM_REQ-1:0] r_req_ready;
  logic               r_tx_start;
  logic [7:0]         r_tx_data;
  logic               r_busy;
  logic               r_timeout_err;

  logic [c_PW-1:0]    w_winner;
  logic [c_TW-1:0]    w_to_inc;

  // Scan downward so the lowest offset from the pointer wins.
  function automatic logic [c_PW-1:0] f_pick(input logic [NUM_REQ-1:0] v,
                                             input logic [c_PW-1:0]    p);
    logic [c_PW-1:0] r;
    int              k;
    r = p;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      k = int'(p) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      if (v[k]) r = c_PW'(k);
    end
    return r;
  endfunction

  always_comb begin
    w_winner = f_pick(bus.req_valid, r_rr);
    w_to_inc = r_to_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= c_IDLE;
      r_rr          <= '0;
      r_owner       <= '0;
      r_last        <= 1'b0;
      r_gap_cnt     <= '0;
      r_to_cnt      <= '0;
      r_grant       <= '0;
      r_req_ready   <= '0;
      r_tx_start    <= 1'b0;
      r_tx_data     <= 8'h00;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_tx_start    <= 1'b0;
      r_req_ready   <= '0;
      r_timeout_err <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (|bus.req_valid) begin
            r_owner  <= w_winner;
            r_grant  <= NUM_REQ'(1) << w_winner;
            r_rr     <= (w_winner == c_PTR_LAST) ? '0 : w_winner + 1'b1;
            r_to_cnt <= '0;
            r_busy   <= 1'b1;
            r_state  <= c_LOAD;
          end
        end
        c_LOAD: begin
          if (bus.req_valid[r_owner]) begin
            r_tx_data   <= bus.req_data[{r_owner, 3'b000} +: 8];
            r_last      <= bus.req_last[r_owner];
            r_tx_start  <= 1'b1;
            r_req_ready <= r_grant;
            r_to_cnt    <= '0;
            r_state     <= c_WAIT;
          end else if (w_to_inc >= c_TO_LIMIT) begin
            r_grant       <= '0;
            r_timeout_err <= 1'b1;
            r_to_cnt      <= '0;
            r_gap_cnt     <= '0;
            r_busy        <= c_AFTER_BUSY;
            r_state       <= c_AFTER_FRAME;
          end else begin
            r_to_cnt <= w_to_inc;
          end
        end
        c_WAIT: begin
          // A done coincident with our own start pulse belongs to an older byte.
          if (bus.tx_done && !r_tx_start) begin
            if (r_last) begin
              r_grant   <= '0;
              r_gap_cnt <= '0;
              r_busy    <= c_AFTER_BUSY;
              r_state   <= c_AFTER_FRAME;
            end else begin
              r_state <= c_LOAD;
            end
          end
        end
        default: begin
          if (r_gap_cnt >= c_GAP_LAST) begin
            r_busy  <= 1'b0;
            r_state <= c_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.grant       = r_grant;
  assign bus.req_ready   = r_req_ready;
  assign bus.tx_start    = r_tx_start;
  assign bus.tx_data     = r_tx_data;
  assign bus.busy        = r_busy;
  assign bus.timeout_err = r_timeout_err;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Purpose  : Directed self-checking bench for uart_tx_arbiter.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_tx_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(4)) bus0 ();
  uart_tx_arbiter_if #(.NUM_REQ(4)) bus1 ();

  uart_tx_arbiter #(.NUM_REQ(4), .GAP_CYCLES(600), .TIMEOUT_CYCLES(4096)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0)
  );
  uart_tx_arbiter #(.NUM_REQ(4), .GAP_CYCLES(0), .TIMEOUT_CYCLES(4096)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive(input int i, input logic [7:0] b, input logic l);
    bus0.req_valid[i]       = 1'b1;
    bus0.req_data[i*8 +: 8] = b;
    bus0.req_last[i]        = l;
  endtask

  task automatic drop(input int i);
    bus0.req_valid[i] = 1'b0;
    bus0.req_last[i]  = 1'b0;
  endtask

  task automatic wait_start(input string tag, input logic [7:0] b, input logic [3:0] rdy);
    int n = 0;
    do begin step(); n++; end while (!bus0.tx_start && n < 50);
    chk({tag, "_start"}, 32'(bus0.tx_start), 32'd1);
    chk({tag, "_data"},  32'(bus0.tx_data),  32'(b));
    chk({tag, "_ready"}, 32'(bus0.req_ready), 32'(rdy));
  endtask

  // UART model: done pulse sampled 10 clocks after the start pulse.
  task automatic uart_done();
    step();
    chk("single_start", 32'(bus0.tx_start), 32'd0);
    chk("ready_pulse",  32'(bus0.req_ready), 32'd0);
    repeat (8) step();
    bus0.tx_done = 1'b1;
    step();
    bus0.tx_done = 1'b0;
  endtask

  task automatic wait_grant(input string tag, input logic [3:0] g, input int lat);
    int n = 0;
    do begin step(); n++; end while (bus0.grant == 4'b0 && n < 2000);
    chk({tag, "_grant"}, 32'(bus0.grant), 32'(g));
    chk({tag, "_lat"},   32'(n), 32'(lat));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus0.req_valid = '0; bus0.req_data = '0; bus0.req_last = '0; bus0.tx_done = 1'b0;
    bus1.req_valid = '0; bus1.req_data = '0; bus1.req_last = '0; bus1.tx_done = 1'b0;
    repeat (3) step();
    chk("rst_grant",   32'(bus0.grant), 32'd0);
    chk("rst_ready",   32'(bus0.req_ready), 32'd0);
    chk("rst_start",   32'(bus0.tx_start), 32'd0);
    chk("rst_data",    32'(bus0.tx_data), 32'd0);
    chk("rst_busy",    32'(bus0.busy), 32'd0);
    chk("rst_timeout", 32'(bus0.timeout_err), 32'd0);
    rst_n = 1'b1;
    step();

    // T1: three-byte frame from requester 0, then 600-cycle gap.
    drive(0, "C", 1'b0);
    step();
    chk("t1_grant", 32'(bus0.grant), 32'd1);
    chk("t1_busy",  32'(bus0.busy), 32'd1);
    wait_start("t1_b0", "C", 4'b0001);
    drive(0, "1", 1'b0);
    uart_done();
    wait_start("t1_b1", "1", 4'b0001);
    drive(0, "2", 1'b1);
    uart_done();
    wait_start("t1_b2", "2", 4'b0001);
    drop(0);
    uart_done();
    chk("t1_grant_off", 32'(bus0.grant), 32'd0);
    repeat (599) step();
    chk("t1_gap_busy", 32'(bus0.busy), 32'd1);
    step();
    chk("t1_gap_end", 32'(bus0.busy), 32'd0);

    // T2: requesters 1 and 3 together, then 0 and 1 (pointer wraps).
    drive(1, 8'h11, 1'b1);
    drive(3, 8'h33, 1'b1);
    step();
    chk("t2_first", 32'(bus0.grant), 32'b0010);
    wait_start("t2_r1", 8'h11, 4'b0010);
    drop(1);
    uart_done();
    wait_grant("t2_second", 4'b1000, 601);
    wait_start("t2_r3", 8'h33, 4'b1000);
    drop(3);
    uart_done();
    drive(0, 8'h40, 1'b1);
    drive(1, 8'h41, 1'b1);
    wait_grant("t2_wrap", 4'b0001, 601);
    wait_start("t2_r0", 8'h40, 4'b0001);
    drop(0);
    uart_done();
    wait_grant("t2_next", 4'b0010, 601);
    wait_start("t2_r1b", 8'h41, 4'b0010);
    drop(1);
    uart_done();

    // T3: requester 2 stalls mid-frame, requester 0 waits.
    drive(2, 8'h21, 1'b0);
    drive(0, 8'h0A, 1'b1);
    wait_grant("t3_own", 4'b0100, 601);
    wait_start("t3_b0", 8'h21, 4'b0100);
    drop(2);
    uart_done();
    repeat (4095) step();
    chk("t3_pre_grant", 32'(bus0.grant), 32'b0100);
    chk("t3_pre_err",   32'(bus0.timeout_err), 32'd0);
    chk("t3_nonowner",  32'(bus0.req_ready), 32'd0);
    step();
    chk("t3_revoke", 32'(bus0.grant), 32'd0);
    chk("t3_err",    32'(bus0.timeout_err), 32'd1);
    step();
    chk("t3_err_pulse", 32'(bus0.timeout_err), 32'd0);
    chk("t3_gap_busy",  32'(bus0.busy), 32'd1);
    wait_grant("t3_pending", 4'b0001, 600);
    wait_start("t3_r0", 8'h0A, 4'b0001);
    drop(0);
    uart_done();

    // T5: spurious tx_done in GAP and IDLE.
    repeat (3) step();
    bus0.tx_done = 1'b1;
    step();
    bus0.tx_done = 1'b0;
    chk("t5_gap_busy",  32'(bus0.busy), 32'd1);
    chk("t5_gap_start", 32'(bus0.tx_start), 32'd0);
    repeat (600) step();
    chk("t5_idle", 32'(bus0.busy), 32'd0);
    bus0.tx_done = 1'b1;
    step();
    bus0.tx_done = 1'b0;
    step();
    chk("t5_idle_busy",  32'(bus0.busy), 32'd0);
    chk("t5_idle_grant", 32'(bus0.grant), 32'd0);

    // T5/T6: done during the start cycle is ignored; reset during WAIT of byte 2.
    drive(1, 8'hD1, 1'b0);
    step();
    chk("t6_grant", 32'(bus0.grant), 32'b0010);
    wait_start("t6_b0", 8'hD1, 4'b0010);
    drive(1, 8'hD2, 1'b0);
    bus0.tx_done = 1'b1;
    step();
    bus0.tx_done = 1'b0;
    repeat (3) step();
    chk("t5_no_extra", 32'(bus0.tx_start), 32'd0);
    chk("t5_waiting",  32'(bus0.grant), 32'b0010);
    uart_done();
    wait_start("t6_b1", 8'hD2, 4'b0010);
    drive(1, 8'hD3, 1'b1);
    drive(0, 8'hE0, 1'b1);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_grant", 32'(bus0.grant), 32'd0);
    chk("t6_rst_busy",  32'(bus0.busy), 32'd0);
    chk("t6_rst_data",  32'(bus0.tx_data), 32'd0);
    chk("t6_rst_start", 32'(bus0.tx_start), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("t6_rr_zero", 32'(bus0.grant), 32'b0001);
    wait_start("t6_r0", 8'hE0, 4'b0001);
    drop(0);
    drop(1);
    uart_done();

    // T4: zero gap, back-to-back one-byte frames on the second instance.
    bus1.req_valid[0]  = 1'b1;
    bus1.req_data[7:0] = 8'hA5;
    bus1.req_last[0]   = 1'b1;
    step();
    chk("t4_grant", 32'(bus1.grant), 32'd1);
    step();
    chk("t4_start", 32'(bus1.tx_start), 32'd1);
    chk("t4_data",  32'(bus1.tx_data), 32'hA5);
    bus1.req_data[7:0] = 8'h5A;
    repeat (3) step();
    bus1.tx_done = 1'b1;
    step();
    bus1.tx_done = 1'b0;
    chk("t4_release", 32'(bus1.grant), 32'd0);
    chk("t4_idle",    32'(bus1.busy), 32'd0);
    step();
    chk("t4_regrant", 32'(bus1.grant), 32'd1);
    step();
    chk("t4_start2", 32'(bus1.tx_start), 32'd1);
    chk("t4_data2",  32'(bus1.tx_data), 32'h5A);
    bus1.req_valid[0] = 1'b0;
    step();
    bus1.tx_done = 1'b1;
    step();
    bus1.tx_done = 1'b0;
    step();
    chk("t4_end_busy",  32'(bus1.busy), 32'd0);
    chk("t4_end_grant", 32'(bus1.grant), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
